// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the serial ADC scan sequencer.
package adc_scan_pkg;

    // Sequencer phases: idle, CS setup, 16-clock conversion frames, CS quiet time
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int NUM_CH          = 8;
    localparam int ADC_BITS        = 12;
    localparam int FRAME_HALVES    = 32;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int DATA_FIRST_EDGE = 5;

    // Rising edge that carries the last (LSB) data bit of a frame
    localparam int DATA_LAST_EDGE  = DATA_FIRST_EDGE + ADC_BITS - 1;

endpackage

// File: rtl/adc_chan_picker.sv
// Round-robin channel picker: next set bit of mask strictly after last,
// searching cyclically 1..8 steps so last itself is chosen only when it
// is the sole enabled channel.
module adc_chan_picker
    import adc_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [2:0]        last,
    output logic [2:0]        next,
    output logic              any
);

    logic [2:0] cand;

    // Scan from the farthest step down so the nearest set bit wins
    always_comb begin
        next = last;
        cand = last;
        any  = |mask;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = last + 3'(i);
            if (mask[cand]) begin
                next = cand;
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Serial ADC scan sequencer: generates CS/SCLK/DIN for back-to-back
// 16-clock conversion frames and reports each result as one valid beat.
//
// Output handshake: sample_valid is a one-cycle pulse with no ready;
// sample_chan/sample_data are valid in that cycle and hold until the
// next pulse. There is no backpressure, the consumer must take the beat.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int HALF_DIV = 16
)
(
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   chan_mask,
    output logic                busy,
    output logic                sample_valid,
    output logic [2:0]          sample_chan,
    output logic [ADC_BITS-1:0] sample_data,
    output logic                ADC_CS_N,
    output logic                ADC_SCLK,
    output logic                ADC_SADDR,
    input  logic                ADC_SDAT,
    output state_e              dbg_state
);

    localparam logic [7:0] DIV_LAST  = 8'(HALF_DIV - 1);
    localparam logic [4:0] HALF_LAST = 5'(FRAME_HALVES - 1);

    state_e                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [4:0]            h_q, h_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  saddr_q, saddr_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [2:0]            chan_q, chan_d;
    logic [ADC_BITS-1:0]   data_q, data_d;
    logic [ADC_BITS-1:0]   shift_q, shift_d;
    logic [NUM_CH-1:0]     mask_lat_q, mask_lat_d;
    logic [2:0]            conv_chan_q, conv_chan_d;
    logic [2:0]            next_addr_q, next_addr_d;
    logic [2:0]            last_addr_q, last_addr_d;

    logic                  begin_frame;
    logic                  div_last;
    logic [4:0]            h_n;
    logic [4:0]            edge_k;
    logic [1:0]            addr_off;
    logic [ADC_BITS-1:0]   shift_in;
    logic [2:0]            pick_last;
    logic [2:0]            pick_next;
    logic                  pick_any;

    // Between chained frames last_addr has not yet taken next_addr, so
    // the picker must search from the address of the frame just ending.
    assign pick_last = (state_q == SHIFT) ? next_addr_q : last_addr_q;

    adc_chan_picker u_picker (
        .mask (chan_mask),
        .last (pick_last),
        .next (pick_next),
        .any  (pick_any)
    );

    // Next-state and output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        h_d         = h_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        saddr_d     = saddr_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        chan_d      = chan_q;
        data_d      = data_q;
        shift_d     = shift_q;
        mask_lat_d  = mask_lat_q;
        conv_chan_d = conv_chan_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        begin_frame = 1'b0;

        div_last = (div_q == DIV_LAST);
        h_n      = h_q + 5'd1;
        // Entering half h_n is edge k = h_n/2+1 (falling, even) or
        // (h_n+1)/2 (rising, odd); both reduce to h_n[4:1]+1.
        edge_k   = {1'b0, h_n[4:1]} + 5'd1;
        addr_off = 2'(edge_k - 5'(ADDR_FIRST_EDGE));
        shift_in = {shift_q[ADC_BITS-2:0], ADC_SDAT};

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (enable && pick_any) begin
                    state_d     = START;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b1;
                    saddr_d     = 1'b0;
                    busy_d      = 1'b1;
                    div_d       = 8'd0;
                    // The ADC converts IN0 on the first frame after CS falls
                    last_addr_d = 3'd0;
                end
            end

            START: begin
                if (div_last) begin
                    begin_frame = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + 8'd1;
                end else if (h_q == HALF_LAST) begin
                    last_addr_d = next_addr_q;
                    if (enable && pick_any) begin
                        begin_frame = 1'b1;
                    end else begin
                        state_d = STOP;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        saddr_d = 1'b0;
                        div_d   = 8'd0;
                    end
                end else begin
                    h_d   = h_n;
                    div_d = 8'd0;
                    if (h_n[0]) begin
                        // Rising SCLK: sample DOUT on this same clock edge
                        sclk_d = 1'b1;
                        if (edge_k >= 5'(DATA_FIRST_EDGE)) begin
                            shift_d = shift_in;
                        end
                        if (edge_k == 5'(DATA_LAST_EDGE)) begin
                            if (mask_lat_q[conv_chan_q]) begin
                                valid_d = 1'b1;
                                chan_d  = conv_chan_q;
                                data_d  = shift_in;
                            end
                        end
                    end else begin
                        // Falling SCLK: DIN changes only here
                        sclk_d  = 1'b0;
                        saddr_d = 1'b0;
                        if (edge_k >= 5'(ADDR_FIRST_EDGE) &&
                            edge_k <  5'(ADDR_FIRST_EDGE + 3)) begin
                            case (addr_off)
                                2'd0:    saddr_d = next_addr_q[2];
                                2'd1:    saddr_d = next_addr_q[1];
                                default: saddr_d = next_addr_q[0];
                            endcase
                        end
                    end
                end
            end

            STOP: begin
                if (div_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start: latch mask, fix converted and next channel, first fall
        if (begin_frame) begin
            state_d     = SHIFT;
            mask_lat_d  = chan_mask;
            conv_chan_d = pick_last;
            next_addr_d = pick_next;
            h_d         = 5'd0;
            div_d       = 8'd0;
            sclk_d      = 1'b0;
            saddr_d     = 1'b0;
            cs_n_d      = 1'b0;
            busy_d      = 1'b1;
        end
    end

    // Sequencer state and registered pin/result outputs
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            h_q         <= 5'd0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            saddr_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= 3'd0;
            data_q      <= '0;
            shift_q     <= '0;
            mask_lat_q  <= '0;
            conv_chan_q <= 3'd0;
            next_addr_q <= 3'd0;
            last_addr_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            h_q         <= h_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            saddr_q     <= saddr_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            mask_lat_q  <= mask_lat_d;
            conv_chan_q <= conv_chan_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_chan  = chan_q;
    assign sample_data  = data_q;
    assign ADC_CS_N     = cs_n_q;
    assign ADC_SCLK     = sclk_q;
    assign ADC_SADDR    = saddr_q;
    assign dbg_state    = state_q;

endmodule
